// File: rtl/width_pack_gearbox.sv
// width_pack_gearbox: packs IN_W beats MSB-first into OUT_W words. A word appears one cycle after
// its completing beat; a stalled output word blocks input. Define PACK_LAST_EN for packet last/flush.
module width_pack_gearbox #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [IN_W-1:0]  data_in,
`ifdef PACK_LAST_EN
  input  logic             last_in,
  output logic             last_out,
`endif
  output logic             valid_out,
  input  logic             ready_out,
  output logic [OUT_W-1:0] data_out
);
  localparam int CW = $clog2(OUT_W+1);
  localparam int SW = $clog2(OUT_W+IN_W+1);
  localparam int EW = OUT_W+IN_W;

  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] dout_q, dout_d;
  logic [CW-1:0]    fill_q, fill_d;
  logic             vout_q, vout_d;
  logic [SW-1:0]    sum;
  logic [EW-1:0]    ext;
  logic [OUT_W-1:0] ext_hi, ext_lo;
  logic             accept, complete, slot_free;

  // ext: accumulator bits followed immediately by the new beat, left-aligned
  assign sum       = SW'(fill_q) + SW'(IN_W);
  assign ext       = {acc_q, {IN_W{1'b0}}} | ({data_in, {OUT_W{1'b0}}} >> fill_q);
  assign ext_hi    = ext[EW-1:IN_W];
  assign ext_lo    = {ext[IN_W-1:0], {(OUT_W-IN_W){1'b0}}};
  assign complete  = (sum >= SW'(OUT_W));
  assign slot_free = !vout_q || ready_out;
  assign accept    = valid_in && ready_in;

`ifdef PACK_LAST_EN
  typedef enum logic {ACC, FLUSH} state_t;
  state_t state_q, state_d;
  logic   last_q, last_d;

  assign ready_in = (state_q == ACC) && slot_free;
  assign last_out = last_q;
`else
  assign ready_in = slot_free;
`endif

  assign valid_out = vout_q;
  assign data_out  = dout_q;

  always_comb begin
    acc_d  = acc_q;
    fill_d = fill_q;
    dout_d = dout_q;
    vout_d = vout_q && !ready_out;
`ifdef PACK_LAST_EN
    state_d = state_q;
    last_d  = (vout_q && !ready_out) ? last_q : 1'b0;
`endif
    if (accept) begin
      if (complete) begin
        dout_d = ext_hi;
        vout_d = 1'b1;
        acc_d  = ext_lo;
        fill_d = CW'(sum - SW'(OUT_W));
`ifdef PACK_LAST_EN
        last_d = 1'b0;
        if (last_in) begin
          if (sum == SW'(OUT_W)) begin
            last_d = 1'b1;
            acc_d  = '0;
            fill_d = '0;
          end else begin
            state_d = FLUSH;
          end
        end
`endif
      end else begin
        acc_d  = ext_hi;
        fill_d = CW'(sum);
`ifdef PACK_LAST_EN
        if (last_in) begin
          dout_d = ext_hi;
          vout_d = 1'b1;
          last_d = 1'b1;
          acc_d  = '0;
          fill_d = '0;
        end
`endif
      end
    end
`ifdef PACK_LAST_EN
    // residue word replaces the full word in the same cycle the full word is taken
    if (state_q == FLUSH && vout_q && ready_out) begin
      dout_d  = acc_q;
      vout_d  = 1'b1;
      last_d  = 1'b1;
      acc_d   = '0;
      fill_d  = '0;
      state_d = ACC;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      fill_q  <= '0;
      dout_q  <= '0;
      vout_q  <= 1'b0;
`ifdef PACK_LAST_EN
      state_q <= ACC;
      last_q  <= 1'b0;
`endif
    end else begin
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      dout_q  <= dout_d;
      vout_q  <= vout_d;
`ifdef PACK_LAST_EN
      state_q <= state_d;
      last_q  <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_width_pack_gearbox.sv
`timescale 1ns/1ps
module tb_width_pack_gearbox;
  localparam int IN_W  = 24;
  localparam int OUT_W = 128;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             valid_in = 1'b0;
  logic             ready_in;
  logic [IN_W-1:0]  data_in = '0;
  logic             last_in = 1'b0;
  logic             valid_out;
  logic             ready_out = 1'b1;
  logic [OUT_W-1:0] data_out;
`ifdef PACK_LAST_EN
  logic             last_out;
`endif

  int n_chk = 0;
  int n_bad = 0;
  int words_seen = 0;
  bit               bitq[$];
  logic [OUT_W-1:0] expw[$];
  bit               expl[$];
  logic [OUT_W-1:0] hold;
  bit               rnd_done;

  width_pack_gearbox #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_in (valid_in),
    .ready_in (ready_in),
    .data_in  (data_in),
`ifdef PACK_LAST_EN
    .last_in  (last_in),
    .last_out (last_out),
`endif
    .valid_out(valid_out),
    .ready_out(ready_out),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  function automatic logic [OUT_W-1:0] w1(logic x);
    return {{(OUT_W-1){1'b0}}, x};
  endfunction

  function automatic logic [OUT_W-1:0] wi(int x);
    return OUT_W'(x);
  endfunction

  task automatic check(string tag, logic [OUT_W-1:0] got, logic [OUT_W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  // Reference: the stream is a plain bit queue; every OUT_W bits is one word, a last beat pads with zeros.
  task automatic model_push(logic [IN_W-1:0] d, bit last);
    for (int i = IN_W-1; i >= 0; i--) bitq.push_back(d[i]);
    if (last) while (bitq.size() % OUT_W != 0) bitq.push_back(1'b0);
    while (bitq.size() >= OUT_W) begin
      logic [OUT_W-1:0] w;
      for (int i = OUT_W-1; i >= 0; i--) w[i] = bitq.pop_front();
      expw.push_back(w);
      expl.push_back(last && bitq.size() == 0);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      bitq.delete();
      expw.delete();
      expl.delete();
    end else begin
      if (valid_out && ready_out) begin
        words_seen++;
        if (expw.size() == 0) begin
          check("word_unexpected", w1(valid_out), w1(1'b0));
        end else begin
          logic [OUT_W-1:0] ew;
          bit el;
          ew = expw.pop_front();
          el = expl.pop_front();
          check("word", data_out, ew);
`ifdef PACK_LAST_EN
          check("last_out", w1(last_out), w1(el));
`endif
        end
      end
`ifndef PACK_LAST_EN
      check("ready_in_rule", w1(ready_in), w1(!(valid_out && !ready_out)));
`endif
      if (valid_in && ready_in) model_push(data_in, last_in);
    end
  end

  task automatic send_beat(logic [IN_W-1:0] d, bit last);
    bit ok;
    ok = 1'b0;
    valid_in = 1'b1;
    data_in  = d;
    last_in  = last;
    for (int c = 0; c < 1000 && !ok; c++) begin
      @(negedge clk);
      ok = ready_in;
      @(posedge clk);
      #1;
    end
    if (!ok) check("send_timeout", w1(ok), w1(1'b1));
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_vout", w1(valid_out), w1(1'b0));
    check("rst_dout", data_out, '0);
`ifdef PACK_LAST_EN
    check("rst_last", w1(last_out), w1(1'b0));
`endif
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_chk, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int s1_start;
    #12;
    check("reset_vout", w1(valid_out), w1(1'b0));
    check("reset_dout", data_out, '0);
    check("reset_rdy_in", w1(ready_in), w1(1'b1));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 16 counting beats -> 3 words after beats 6, 11, 16
    s1_start = words_seen;
    for (int i = 1; i <= 16; i++) begin
      send_beat(IN_W'(i), 1'b0);
      check($sformatf("s1_vout_b%0d", i), w1(valid_out), w1(i == 6 || i == 11 || i == 16));
      if (i == 6)
        check("s1_word0", data_out, {24'h000001, 24'h000002, 24'h000003, 24'h000004, 24'h000005, 8'h00});
    end
    repeat (2) begin @(posedge clk); #1; end
    check("s1_words", wi(words_seen - s1_start), wi(3));

    // same stream with a 4-cycle stall on word0
    fork
      begin
        for (int i = 1; i <= 16; i++) send_beat(IN_W'(i), 1'b0);
      end
      begin
        int c;
        c = 0;
        while (!valid_out && c < 200) begin @(posedge clk); #1; c++; end
        check("s2_word0_seen", w1(valid_out), w1(1'b1));
        ready_out = 1'b0;
        hold = data_out;
        check("s2_word0", hold, {24'h000001, 24'h000002, 24'h000003, 24'h000004, 24'h000005, 8'h00});
        repeat (4) begin
          @(negedge clk);
          check("s2_rdy_in", w1(ready_in), w1(1'b0));
          check("s2_hold", data_out, hold);
          check("s2_vout", w1(valid_out), w1(1'b1));
          @(posedge clk); #1;
        end
        ready_out = 1'b1;
      end
    join
    repeat (3) begin @(posedge clk); #1; end
    check("s2_drain", wi(expw.size()), wi(0));

    // reset mid-packet drops buffered bits
    for (int i = 0; i < 4; i++) send_beat(IN_W'($urandom), 1'b0);
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      send_beat(24'hA00000 + IN_W'(i), 1'b0);
      check($sformatf("s5_vout_b%0d", i), w1(valid_out), w1(i == 6));
    end
    check("s5_word0", data_out, {24'hA00001, 24'hA00002, 24'hA00003, 24'hA00004, 24'hA00005, 8'hA0});
    @(posedge clk); #1;

`ifdef PACK_LAST_EN
    do_reset();
    send_beat(24'hAAAAAA, 1'b0);
    send_beat(24'hBBBBBB, 1'b0);
    send_beat(24'hCCCCCC, 1'b1);
    check("s3_vout", w1(valid_out), w1(1'b1));
    check("s3_word", data_out, {72'hAAAAAABBBBBBCCCCCC, 56'h0});
    check("s3_last", w1(last_out), w1(1'b1));
    @(posedge clk); #1;
    for (int i = 1; i <= 6; i++) send_beat(IN_W'(i) * 24'h111111, i == 6);
    check("s4_full", data_out, {24'h111111, 24'h222222, 24'h333333, 24'h444444, 24'h555555, 8'h66});
    check("s4_full_last", w1(last_out), w1(1'b0));
    check("s4_rdy_in", w1(ready_in), w1(1'b0));
    @(posedge clk); #1;
    check("s4_resid_vout", w1(valid_out), w1(1'b1));
    check("s4_resid", data_out, {16'h6666, 112'h0});
    check("s4_resid_last", w1(last_out), w1(1'b1));
    @(posedge clk); #1;
`endif

    // random stream with random gaps and random downstream stalls
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 2000; i++) begin
          if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
`ifdef PACK_LAST_EN
          send_beat(IN_W'($urandom), $urandom_range(0, 19) == 0);
`else
          send_beat(IN_W'($urandom), 1'b0);
`endif
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          ready_out = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        ready_out = 1'b1;
      end
    join
    repeat (10) begin @(posedge clk); #1; end
    check("s6_drain", wi(expw.size()), wi(0));
    check("s6_idle_vout", w1(valid_out), w1(1'b0));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
